// File: rtl/hough_vote_generator_pkg.sv
// Shared defaults, FSM state type and angle helper for the Hough vote generator.
package hough_pkg;

  localparam int DEF_X_W        = 10;
  localparam int DEF_Y_W        = 9;
  localparam int DEF_N_ANGLES   = 45;
  localparam int DEF_ANGLE_STEP = 4;
  localparam int DEF_IDX_W      = 8;
  localparam int DEF_FRAC_W     = 12;
  localparam int DEF_R_W        = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int deg_of_idx(input int idx, input int step);
    return idx * step;
  endfunction

endpackage

// File: rtl/hough_vote_generator_trig_rom.sv
// Combinational trig table: angle index -> {cos signed, sin unsigned}, both scaled by 2**FRAC_W.
// Entries are computed at elaboration with integer Q30 arithmetic, so no real-valued math is synthesised.
module hough_trig_rom
  import hough_pkg::*;
#(
  parameter int N_ANGLES   = DEF_N_ANGLES,
  parameter int ANGLE_STEP = DEF_ANGLE_STEP,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int FRAC_W     = DEF_FRAC_W
) (
  input  logic [IDX_W-1:0]         idx,
  output logic signed [FRAC_W+1:0] cos_o,
  output logic [FRAC_W:0]          sin_o
);

  localparam longint ONE_Q = 64'sd1 <<< 30;
  localparam longint PI_Q  = 64'sd3373259426;

  // Fold the angle into 0..45 degrees, then a short Taylor series keeps Q30 accuracy.
  function automatic longint trig_q30(input int deg, input bit want_cos);
    int     d;
    bit     use_cos;
    bit     neg;
    longint x;
    longint x2;
    longint term;
    longint acc;
    d       = deg;
    use_cos = want_cos;
    neg     = 1'b0;
    if (d > 90) begin
      d   = 180 - d;
      neg = want_cos;
    end
    if (d > 45) begin
      d       = 90 - d;
      use_cos = ~use_cos;
    end
    x    = longint'(d) * PI_Q / 64'sd180;
    x2   = (x * x) >>> 30;
    acc  = use_cos ? ONE_Q : x;
    term = acc;
    for (int k = 1; k <= 10; k++) begin
      term = -((term * x2) >>> 30) / longint'(use_cos ? (2 * k - 1) * (2 * k) : (2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return neg ? -acc : acc;
  endfunction

  function automatic longint q30_to_frac(input longint v);
    longint mag;
    longint r;
    mag = (v < 64'sd0) ? -v : v;
    r   = (mag + (64'sd1 <<< (29 - FRAC_W))) >>> (30 - FRAC_W);
    return (v < 64'sd0) ? -r : r;
  endfunction

  logic signed [FRAC_W+1:0] cos_tab [N_ANGLES];
  logic [FRAC_W:0]          sin_tab [N_ANGLES];

  for (genvar g = 0; g < N_ANGLES; g++) begin : g_tab
    localparam longint COS_C = q30_to_frac(trig_q30(deg_of_idx(g, ANGLE_STEP), 1'b1));
    localparam longint SIN_C = q30_to_frac(trig_q30(deg_of_idx(g, ANGLE_STEP), 1'b0));
    assign cos_tab[g] = (FRAC_W + 2)'(COS_C);
    assign sin_tab[g] = (FRAC_W + 1)'(SIN_C);
  end

  // Table select; indices past the last bin read as zero.
  always_comb begin
    cos_o = '0;
    sin_o = '0;
    for (int i = 0; i < N_ANGLES; i++) begin
      if (idx == IDX_W'(i)) begin
        cos_o = cos_tab[i];
        sin_o = sin_tab[i];
      end
    end
  end

endmodule

// File: rtl/hough_vote_generator.sv
// Hough vote generator: accepts one edge point and streams (r, angle index) votes over an
// angle window through a two-stage multiply / round pipeline under valid/ready backpressure.
module hough_vote_generator
  import hough_pkg::*;
#(
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int N_ANGLES   = DEF_N_ANGLES,
  parameter int ANGLE_STEP = DEF_ANGLE_STEP,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int R_W        = DEF_R_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  input  logic [X_W-1:0]        pt_x,
  input  logic [Y_W-1:0]        pt_y,
  input  logic [IDX_W-1:0]      cfg_first,
  input  logic [IDX_W-1:0]      cfg_count,
  output logic                  vote_valid,
  input  logic                  vote_ready,
  output logic signed [R_W-1:0] vote_r,
  output logic [IDX_W-1:0]      vote_idx,
  output logic                  vote_last,
  output logic                  done
);

  localparam int CP_W = X_W + FRAC_W + 3;
  localparam int SP_W = Y_W + FRAC_W + 1;
  localparam int S_W  = X_W + Y_W + FRAC_W + 4;
  localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N_ANGLES);
  localparam logic [S_W-1:0]   HALF  = S_W'(64'd1 << (FRAC_W - 1));

  state_e                   state_q, state_d;
  logic [X_W-1:0]           x_q, x_d;
  logic [Y_W-1:0]           y_q, y_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         remain_q, remain_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [CP_W-1:0]   s1_cprod_q, s1_cprod_d;
  logic [SP_W-1:0]          s1_sprod_q, s1_sprod_d;
  logic [IDX_W-1:0]         s1_idx_q, s1_idx_d;
  logic                     s1_last_q, s1_last_d;
  logic                     vote_valid_q, vote_valid_d;
  logic signed [R_W-1:0]    vote_r_q, vote_r_d;
  logic [IDX_W-1:0]         vote_idx_q, vote_idx_d;
  logic                     vote_last_q, vote_last_d;
  logic                     done_q, done_d;

  logic                     en_s, accept_s, issue_s;
  logic [IDX_W-1:0]         first_mod_s, count_eff_s;
  logic [X_W-1:0]           src_x_s;
  logic [Y_W-1:0]           src_y_s;
  logic [IDX_W-1:0]         src_idx_s, src_remain_s;
  logic signed [FRAC_W+1:0] rom_cos_s;
  logic [FRAC_W:0]          rom_sin_s;
  logic [S_W-1:0]           sum_s;

  hough_trig_rom #(
    .N_ANGLES  (N_ANGLES),
    .ANGLE_STEP(ANGLE_STEP),
    .IDX_W     (IDX_W),
    .FRAC_W    (FRAC_W)
  ) u_rom (
    .idx  (src_idx_s),
    .cos_o(rom_cos_s),
    .sin_o(rom_sin_s)
  );

  // The accept cycle feeds stage 1 straight from the ports so the first vote lands two cycles later.
  always_comb begin
    en_s        = ~vote_valid_q | vote_ready;
    accept_s    = (state_q == IDLE) & pt_valid;
    first_mod_s = cfg_first % N_IDX;
    if ((cfg_count == '0) || (cfg_count > N_IDX)) count_eff_s = N_IDX;
    else count_eff_s = cfg_count;
    if (accept_s) begin
      src_x_s      = pt_x;
      src_y_s      = pt_y;
      src_idx_s    = first_mod_s;
      src_remain_s = count_eff_s;
    end else begin
      src_x_s      = x_q;
      src_y_s      = y_q;
      src_idx_s    = idx_q;
      src_remain_s = remain_q;
    end
    issue_s = accept_s | ((state_q == SWEEP) & en_s);
    sum_s   = {{(S_W - CP_W){s1_cprod_q[CP_W-1]}}, s1_cprod_q} + {{(S_W - SP_W){1'b0}}, s1_sprod_q} + HALF;
  end

  // Next-state for the FSM, index counter and both pipeline stages.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    idx_d        = idx_q;
    remain_d     = remain_q;
    s1_valid_d   = s1_valid_q;
    s1_cprod_d   = s1_cprod_q;
    s1_sprod_d   = s1_sprod_q;
    s1_idx_d     = s1_idx_q;
    s1_last_d    = s1_last_q;
    vote_valid_d = vote_valid_q;
    vote_r_d     = vote_r_q;
    vote_idx_d   = vote_idx_q;
    vote_last_d  = vote_last_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s) state_d = (src_remain_s == IDX_W'(1)) ? DRAIN : SWEEP;
        else state_d = IDLE;
      end
      SWEEP: begin
        if (en_s && (remain_q == IDX_W'(1))) state_d = DRAIN;
        else state_d = SWEEP;
      end
      DRAIN: begin
        if (vote_valid_q && vote_ready && vote_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue_s) begin
      x_d        = src_x_s;
      y_d        = src_y_s;
      idx_d      = (src_idx_s == N_IDX - IDX_W'(1)) ? '0 : src_idx_s + IDX_W'(1);
      remain_d   = src_remain_s - IDX_W'(1);
      s1_valid_d = 1'b1;
      s1_cprod_d = CP_W'($signed({1'b0, src_x_s})) * CP_W'(rom_cos_s);
      s1_sprod_d = SP_W'(src_y_s) * SP_W'(rom_sin_s);
      s1_idx_d   = src_idx_s;
      s1_last_d  = (src_remain_s == IDX_W'(1));
    end else if (en_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (en_s) begin
      vote_valid_d = s1_valid_q;
      vote_last_d  = s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        vote_r_d   = R_W'($signed(sum_s) >>> FRAC_W);
        vote_idx_d = s1_idx_q;
      end else begin
        vote_r_d   = vote_r_q;
        vote_idx_d = vote_idx_q;
      end
    end else begin
      vote_valid_d = vote_valid_q;
      vote_last_d  = vote_last_q;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      idx_q        <= '0;
      remain_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_cprod_q   <= '0;
      s1_sprod_q   <= '0;
      s1_idx_q     <= '0;
      s1_last_q    <= 1'b0;
      vote_valid_q <= 1'b0;
      vote_r_q     <= '0;
      vote_idx_q   <= '0;
      vote_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      idx_q        <= idx_d;
      remain_q     <= remain_d;
      s1_valid_q   <= s1_valid_d;
      s1_cprod_q   <= s1_cprod_d;
      s1_sprod_q   <= s1_sprod_d;
      s1_idx_q     <= s1_idx_d;
      s1_last_q    <= s1_last_d;
      vote_valid_q <= vote_valid_d;
      vote_r_q     <= vote_r_d;
      vote_idx_q   <= vote_idx_d;
      vote_last_q  <= vote_last_d;
      done_q       <= done_d;
    end
  end

  assign pt_ready   = (state_q == IDLE);
  assign vote_valid = vote_valid_q;
  assign vote_r     = vote_r_q;
  assign vote_idx   = vote_idx_q;
  assign vote_last  = vote_last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_hough_vote_generator.sv
// Self-checking bench for hough_vote_generator: real-valued trig reference model, queue scoreboard
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_hough_vote_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [9:0]  pt_x = 10'd0;
  logic [8:0]  pt_y = 9'd0;
  logic [7:0]  cfg_first = 8'd0;
  logic [7:0]  cfg_count = 8'd0;
  logic        vote_valid;
  logic        vote_ready = 1'b1;
  logic signed [11:0] vote_r;
  logic [7:0]  vote_idx;
  logic        vote_last;
  logic        done;

  hough_vote_generator dut (
    .clk(clk), .rst_n(rst_n), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .cfg_first(cfg_first), .cfg_count(cfg_count),
    .vote_valid(vote_valid), .vote_ready(vote_ready), .vote_r(vote_r),
    .vote_idx(vote_idx), .vote_last(vote_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int r; int idx; bit last;} vote_t;
  vote_t exp_q[$];

  int n_checks = 0, n_errors = 0, cyc = 0, rdy_mode = 0;
  int hs_cnt = 0, accept_cyc = 0, done_cyc = 0, first_vote_cyc = -1, first_idx = -1, last_idx = -1;
  int got_r [64];
  bit busy = 1'b0, done_exp = 1'b0, stall_prev = 1'b0;
  int prev_r = 0, prev_idx = 0, prev_last = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_eq(input string name, input int act, input int req);
    check(act == req, name, act, req);
  endtask

  function automatic int m_trig(input int idx, input bit is_cos);
    real a, v;
    a = idx * 4 * 3.14159265358979323846 / 180.0;
    v = (is_cos ? $cos(a) : $sin(a)) * 4096.0;
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int model_r(input int x, input int y, input int idx);
    return (x * m_trig(idx, 1'b1) + y * m_trig(idx, 1'b0) + 2048) >>> 12;
  endfunction

  task automatic model_point(input int x, input int y, input int first, input int count);
    int f, n;
    vote_t v;
    f = first % 45;
    n = (count == 0 || count > 45) ? 45 : count;
    for (int k = 0; k < n; k++) begin
      v.idx  = (f + k) % 45;
      v.r    = model_r(x, y, v.idx);
      v.last = (k == n - 1);
      exp_q.push_back(v);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    vote_ready = (rdy_mode == 0) ? 1'b1 : ~vote_ready;
  end

  // Compare process: every falling edge, DUT outputs against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check_eq("rst pt_ready", int'(pt_ready), 1);
      check_eq("rst vote_valid", int'(vote_valid), 0);
      check_eq("rst vote_last", int'(vote_last), 0);
      check_eq("rst done", int'(done), 0);
      check_eq("rst vote_r", int'($signed(vote_r)), 0);
      check_eq("rst vote_idx", int'(vote_idx), 0);
      exp_q.delete();
      busy = 1'b0; done_exp = 1'b0; stall_prev = 1'b0;
    end else begin
      check_eq("pt_ready", int'(pt_ready), int'(!busy));
      check_eq("done", int'(done), int'(done_exp));
      if (done) done_cyc = cyc;
      done_exp = 1'b0;
      if (stall_prev) begin
        check_eq("stall valid", int'(vote_valid), 1);
        check_eq("stall r", int'($signed(vote_r)), prev_r);
        check_eq("stall idx", int'(vote_idx), prev_idx);
        check_eq("stall last", int'(vote_last), prev_last);
      end
      if (vote_valid) begin
        if (first_vote_cyc < 0) first_vote_cyc = cyc;
        if (exp_q.size() == 0) begin
          check(1'b0, "spurious vote idx", int'(vote_idx), -1);
        end else begin
          check_eq("vote_r", int'($signed(vote_r)), exp_q[0].r);
          check_eq("vote_idx", int'(vote_idx), exp_q[0].idx);
          check_eq("vote_last", int'(vote_last), int'(exp_q[0].last));
          if (vote_ready) begin
            void'(exp_q.pop_front());
            if (hs_cnt == 0) first_idx = int'(vote_idx);
            hs_cnt++;
            got_r[vote_idx[5:0]] = int'($signed(vote_r));
            if (vote_last) begin
              busy = 1'b0;
              done_exp = 1'b1;
              last_idx = int'(vote_idx);
            end
          end
        end
      end
      stall_prev = vote_valid & !vote_ready;
      prev_r = int'($signed(vote_r)); prev_idx = int'(vote_idx); prev_last = int'(vote_last);
      if (pt_valid && pt_ready) begin
        accept_cyc = cyc; busy = 1'b1; hs_cnt = 0; first_vote_cyc = -1;
        for (int i = 0; i < 64; i++) got_r[i] = -9999;
        model_point(int'(pt_x), int'(pt_y), int'(cfg_first), int'(cfg_count));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic offer(input int x, input int y, input int f, input int c, input bit keep);
    int n;
    n = 0;
    pt_x = 10'(x); pt_y = 9'(y); cfg_first = 8'(f); cfg_count = 8'(c); pt_valid = 1'b1;
    @(negedge clk);
    while (!pt_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!pt_ready) check(1'b0, "accept timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) pt_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check(1'b0, "done timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, gap;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    check_eq("model cos idx0", m_trig(0, 1'b1), 4096);
    check_eq("model cos idx22", m_trig(22, 1'b1), 143);
    check_eq("model r(100,0,22)", model_r(100, 0, 22), 3);
    check_eq("model r(100,0,44)", model_r(100, 0, 44), -100);

    offer(0, 0, 0, 0, 1'b0);
    wait_done(200);
    check_eq("t2 done latency", done_cyc - accept_cyc, 47);
    check_eq("t2 first vote latency", first_vote_cyc - accept_cyc, 2);
    check_eq("t2 handshakes", hs_cnt, 45);
    check_eq("t2 last idx", last_idx, 44);

    offer(100, 0, 0, 0, 1'b0);
    wait_done(200);
    check_eq("t3 (100,0) idx0", got_r[0], 100);
    check_eq("t3 (100,0) idx22", got_r[22], 3);
    check_eq("t3 (100,0) idx44", got_r[44], -100);
    offer(0, 200, 0, 0, 1'b0);
    wait_done(200);
    check_eq("t3 (0,200) idx0", got_r[0], 0);
    check_eq("t3 (0,200) idx22", got_r[22], 200);

    rdy_mode = 1;
    offer(639, 479, 0, 0, 1'b0);
    wait_done(400);
    check_eq("t4 handshakes", hs_cnt, 45);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    offer(300, 100, 40, 10, 1'b0);
    wait_done(200);
    check_eq("t5 handshakes", hs_cnt, 10);
    check_eq("t5 first idx", first_idx, 40);
    check_eq("t5 last idx", last_idx, 4);

    offer(50, 60, 0, 0, 1'b0);
    n = 0;
    while (hs_cnt < 9 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("t1 mid-sweep vote_valid", int'(vote_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("t1 pt_ready after release", int'(pt_ready), 1);
    check_eq("t1 no done after reset", int'(done), 0);
    @(posedge clk);
    #1;

    offer(10, 20, 0, 5, 1'b1);
    offer(30, 40, 10, 5, 1'b1);
    gap = accept_cyc - done_cyc;
    check(gap >= 0 && gap <= 1, "t6 gap 1->2", gap, 1);
    offer(500, 7, 43, 5, 1'b0);
    gap = accept_cyc - done_cyc;
    check(gap >= 0 && gap <= 1, "t6 gap 2->3", gap, 1);
    wait_done(200);
    check_eq("t6 last point handshakes", hs_cnt, 5);
    check_eq("t6 last point last idx", last_idx, 2);
    check_eq("scoreboard empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
